// File: rtl/mm_timer.sv
// rtl/mm_timer.sv - memory-mapped countdown timer with interrupt; optional prescaler under TIMER_PRESCALE_EN
module mm_timer #(
   parameter logic [31:0] PRESET_RST = 32'h0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        Sel,
   input  logic [31:0] Addr,
   input  logic        WE,
   input  logic [3:0]  BE,
   input  logic [31:0] WD,
   output logic [31:0] RD,
   output logic        IRQ
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_COUNT = 2'd2,
      S_INT   = 2'd3
   } state_t;

   localparam logic [1:0] A_CTRL      = 2'd0;
   localparam logic [1:0] A_PRESET    = 2'd1;
   localparam logic [1:0] A_COUNT     = 2'd2;
   localparam logic [1:0] A_PRESCALE  = 2'd3;
   localparam logic [1:0] MODE_RELOAD = 2'd1;

   state_t      state;
   logic [3:0]  ctrl;
   logic [31:0] preset;
   logic [31:0] count;
   logic        pending;

   logic        wr;
   logic        wr_ctrl;
   logic        wr_preset;
   logic        ctrl_load;
   logic        force_idle;
   logic        tick;
   logic        pend_set;
   logic        pend_clr;
   logic        unused_addr;

`ifdef TIMER_PRESCALE_EN
   logic [7:0]  prescale;
   logic [7:0]  pcnt;
   logic        wr_prescale;
`endif

   assign wr          = Sel & WE;
   assign wr_ctrl     = wr & (Addr[3:2] == A_CTRL);
   assign wr_preset   = wr & (Addr[3:2] == A_PRESET);
   assign ctrl_load   = wr_ctrl & BE[0];
   assign force_idle  = ctrl_load & ~WD[0];
   assign unused_addr = ^{Addr[31:4], Addr[1:0]};

`ifdef TIMER_PRESCALE_EN
   assign wr_prescale = wr & (Addr[3:2] == A_PRESCALE);
   assign tick        = (pcnt == 8'd0);
`else
   assign tick        = 1'b1;
`endif

   // Expiry sets pending even if a CPU clear lands on the same edge.
   assign pend_set = (state == S_COUNT) & ctrl[0] & (count == 32'd0);
   assign pend_clr = wr_ctrl | wr_preset |
                     ((state == S_INT) & (ctrl[2:1] == MODE_RELOAD));

   assign IRQ = ctrl[3] & pending;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= S_IDLE;
         ctrl     <= 4'd0;
         preset   <= PRESET_RST;
         count    <= 32'd0;
         pending  <= 1'b0;
`ifdef TIMER_PRESCALE_EN
         prescale <= 8'd0;
         pcnt     <= 8'd0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (ctrl[0]) state <= S_LOAD;
            end
            S_LOAD: begin
               count <= preset;
`ifdef TIMER_PRESCALE_EN
               pcnt  <= prescale;
`endif
               state <= S_COUNT;
            end
            S_COUNT: begin
               if (!ctrl[0]) begin
                  state <= S_IDLE;
               end else if (count == 32'd0) begin
                  state <= S_INT;
               end else if (!force_idle) begin
                  // A disabling write freezes COUNT at the value it holds now.
`ifdef TIMER_PRESCALE_EN
                  if (tick) begin
                     count <= count - 32'd1;
                     pcnt  <= prescale;
                  end else begin
                     pcnt  <= pcnt - 8'd1;
                  end
`else
                  if (tick) count <= count - 32'd1;
`endif
               end
            end
            S_INT: begin
               if (ctrl[2:1] == MODE_RELOAD) begin
                  state <= S_LOAD;
               end else begin
                  ctrl[0] <= 1'b0;
                  state   <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase

         if (pend_set) begin
            pending <= 1'b1;
         end else if (pend_clr) begin
            pending <= 1'b0;
         end

         // CPU writes come last so they override FSM updates on the same edge.
         if (ctrl_load) ctrl <= WD[3:0];
         if (force_idle) state <= S_IDLE;

         for (int i = 0; i < 4; i++) begin
            if (wr_preset && BE[i]) preset[8*i +: 8] <= WD[8*i +: 8];
         end

`ifdef TIMER_PRESCALE_EN
         if (wr_prescale && BE[0]) prescale <= WD[7:0];
`endif
      end
   end

   always_comb begin
      RD = 32'd0;
      case (Addr[3:2])
         A_CTRL:     RD = {28'd0, ctrl};
         A_PRESET:   RD = preset;
         A_COUNT:    RD = count;
`ifdef TIMER_PRESCALE_EN
         A_PRESCALE: RD = {24'd0, prescale};
`else
         A_PRESCALE: RD = 32'd0;
`endif
         default:    RD = 32'd0;
      endcase
   end

endmodule

// File: tb/tb_mm_timer.sv
// tb/tb_mm_timer.sv - directed self-checking bench for mm_timer
module tb_mm_timer;

   logic        clk   = 1'b0;
   logic        reset = 1'b1;
   logic        Sel   = 1'b0;
   logic        WE    = 1'b0;
   logic [31:0] Addr  = 32'd0;
   logic [3:0]  BE    = 4'd0;
   logic [31:0] WD    = 32'd0;
   logic [31:0] RD;
   logic        IRQ;

   int n_checks = 0;
   int n_errors = 0;

   localparam logic [31:0] RST_PRESET = 32'h0000_0007;
`ifdef TIMER_PRESCALE_EN
   localparam logic [31:0] PS_FF   = 32'h0000_00FF;
   localparam int          ONE_LAT = 7;
`else
   localparam logic [31:0] PS_FF   = 32'h0000_0000;
   localparam int          ONE_LAT = 5;
`endif

   always #5 clk = ~clk;

   mm_timer #(.PRESET_RST(RST_PRESET)) dut (
      .clk   (clk),
      .reset (reset),
      .Sel   (Sel),
      .Addr  (Addr),
      .WE    (WE),
      .BE    (BE),
      .WD    (WD),
      .RD    (RD),
      .IRQ   (IRQ)
   );

   typedef struct {
      logic        sel;
      logic        wr;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wd;
      logic [31:0] exp_rd;
   } vec_t;

   vec_t vecs [16];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic bus_write(input logic sel, input logic [31:0] a, input logic [3:0] be,
                            input logic [31:0] d);
      Sel  = sel;
      WE   = 1'b1;
      Addr = a;
      BE   = be;
      WD   = d;
      @(posedge clk);
      #1;
      Sel  = 1'b0;
      WE   = 1'b0;
      BE   = 4'd0;
      WD   = 32'd0;
   endtask

   task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
      Addr = a;
      #1;
      d = RD;
   endtask

   initial begin
      logic [31:0] rd_val;
      logic        exp_irq;
      int          p;

      vecs[0]  = '{1'b0, 1'b0, 32'h00, 4'h0, 32'h0,         32'h0};
      vecs[1]  = '{1'b0, 1'b0, 32'h04, 4'h0, 32'h0,         RST_PRESET};
      vecs[2]  = '{1'b0, 1'b0, 32'h08, 4'h0, 32'h0,         32'h0};
      vecs[3]  = '{1'b0, 1'b0, 32'h0C, 4'h0, 32'h0,         32'h0};
      vecs[4]  = '{1'b1, 1'b1, 32'h04, 4'hF, 32'h0,         32'h0};
      vecs[5]  = '{1'b1, 1'b1, 32'h04, 4'h5, 32'hAABBCCDD,  32'h00BB00DD};
      vecs[6]  = '{1'b1, 1'b1, 32'h04, 4'hA, 32'h11223344,  32'h11BB33DD};
      vecs[7]  = '{1'b1, 1'b1, 32'h08, 4'hF, 32'hFFFFFFFF,  32'h0};
      vecs[8]  = '{1'b1, 1'b1, 32'h00, 4'hE, 32'hFFFFFFFF,  32'h0};
      vecs[9]  = '{1'b1, 1'b1, 32'h00, 4'h1, 32'hFFFFFFF6,  32'h6};
      vecs[10] = '{1'b1, 1'b1, 32'h14, 4'hF, 32'h12345678,  32'h12345678};
      vecs[11] = '{1'b0, 1'b1, 32'h04, 4'hF, 32'h0,         32'h12345678};
      vecs[12] = '{1'b0, 1'b0, 32'h24, 4'h0, 32'h0,         32'h12345678};
      vecs[13] = '{1'b1, 1'b1, 32'h0C, 4'hF, 32'h000001FF,  PS_FF};
      vecs[14] = '{1'b1, 1'b1, 32'h0C, 4'hF, 32'h0,         32'h0};
      vecs[15] = '{1'b1, 1'b1, 32'h00, 4'h1, 32'h0,         32'h0};

      #1;
      check("irq_in_reset", {31'd0, IRQ}, 32'd0);
      cyc(2);
      reset = 1'b0;
      cyc(1);

      for (int i = 0; i < 16; i++) begin
         if (vecs[i].wr) bus_write(vecs[i].sel, vecs[i].addr, vecs[i].be, vecs[i].wd);
         bus_read(vecs[i].addr, rd_val);
         check($sformatf("vec%0d", i), rd_val, vecs[i].exp_rd);
      end

      // One-shot, PRESET=3: IRQ rises after the sixth edge and holds.
      bus_write(1'b1, 32'h4, 4'hF, 32'd3);
      bus_write(1'b1, 32'h0, 4'h1, 32'h9);
      cyc(5);
      check("oneshot_irq_e5", {31'd0, IRQ}, 32'd0);
      cyc(1);
      check("oneshot_irq_e6", {31'd0, IRQ}, 32'd1);
      cyc(1);
      bus_read(32'h0, rd_val);
      check("oneshot_ctrl_after", rd_val, 32'h8);
      cyc(3);
      check("oneshot_irq_held", {31'd0, IRQ}, 32'd1);
      bus_write(1'b1, 32'h4, 4'hF, 32'd3);
      check("oneshot_irq_cleared", {31'd0, IRQ}, 32'd0);

      // Auto-reload, PRESET=2: one-cycle IRQ every 5 edges, COUNT 2,1,0.
      bus_write(1'b1, 32'h4, 4'hF, 32'd2);
      bus_write(1'b1, 32'h0, 4'h1, 32'hB);
      for (int e = 1; e <= 22; e++) begin
         cyc(1);
         exp_irq = (e >= 5) && (((e - 5) % 5) == 0);
         check($sformatf("reload_irq_e%0d", e), {31'd0, IRQ}, {31'd0, exp_irq});
         if (e >= 2) begin
            p = (e - 2) % 5;
            if (p < 3) begin
               bus_read(32'h8, rd_val);
               check($sformatf("reload_count_e%0d", e), rd_val, 32'(2 - p));
            end
         end
      end

      // Disable mid-count with IM kept: COUNT freezes at 2.
      bus_write(1'b1, 32'h0, 4'h1, 32'h8);
      bus_read(32'h8, rd_val);
      check("disable_count_now", rd_val, 32'd2);
      cyc(5);
      bus_read(32'h8, rd_val);
      check("disable_count_later", rd_val, 32'd2);
      check("disable_irq", {31'd0, IRQ}, 32'd0);

      // Masked one-shot: pending is set but IRQ stays low.
      bus_write(1'b1, 32'h4, 4'hF, 32'd1);
      bus_write(1'b1, 32'h0, 4'h1, 32'h1);
      for (int e = 1; e <= 6; e++) begin
         cyc(1);
         check($sformatf("masked_irq_e%0d", e), {31'd0, IRQ}, 32'd0);
      end
      check("masked_pending", {31'd0, dut.pending}, 32'd1);
      bus_read(32'h0, rd_val);
      check("masked_ctrl", rd_val, 32'h0);
      bus_write(1'b1, 32'h4, 4'hF, 32'd1);
      check("masked_pending_clr", {31'd0, dut.pending}, 32'd0);

      // Reset in the middle of a count of 10 when COUNT=5.
      bus_write(1'b1, 32'h4, 4'hF, 32'd10);
      bus_write(1'b1, 32'h0, 4'h1, 32'h9);
      cyc(7);
      bus_read(32'h8, rd_val);
      check("prereset_count", rd_val, 32'd5);
      reset = 1'b1;
      bus_read(32'h8, rd_val);
      check("reset_count", rd_val, 32'd0);
      bus_read(32'h0, rd_val);
      check("reset_ctrl", rd_val, 32'd0);
      bus_read(32'h4, rd_val);
      check("reset_preset", rd_val, RST_PRESET);
      check("reset_irq", {31'd0, IRQ}, 32'd0);
      cyc(2);
      reset = 1'b0;
      cyc(15);
      bus_read(32'h8, rd_val);
      check("postreset_count", rd_val, 32'd0);
      check("postreset_irq", {31'd0, IRQ}, 32'd0);

      // Latency with PRESET=2 (PRESCALE=1 when the prescaler is built in).
`ifdef TIMER_PRESCALE_EN
      bus_write(1'b1, 32'hC, 4'hF, 32'd1);
`endif
      bus_write(1'b1, 32'h4, 4'hF, 32'd2);
      bus_write(1'b1, 32'h0, 4'h1, 32'h9);
      cyc(ONE_LAT - 1);
      check("lat_irq_before", {31'd0, IRQ}, 32'd0);
      cyc(1);
      check("lat_irq_at", {31'd0, IRQ}, 32'd1);

      // PRESET=0: LOAD, COUNT, INT with no decrement.
      bus_write(1'b1, 32'h4, 4'hF, 32'd0);
      check("zero_irq_clr", {31'd0, IRQ}, 32'd0);
      bus_write(1'b1, 32'h0, 4'h1, 32'h9);
      cyc(2);
      check("zero_irq_e2", {31'd0, IRQ}, 32'd0);
      cyc(1);
      check("zero_irq_e3", {31'd0, IRQ}, 32'd1);
      bus_read(32'h8, rd_val);
      check("zero_count", rd_val, 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/mm_timer.md
# mm_timer

Memory-mapped countdown timer that acts as the responder on the CPU data-memory port. The pipeline's M-stage store/load path, via the system bridge, drives address, write enable, byte enables and write data; the block returns read data and raises an interrupt request. It is the first peripheral hung off the data bus beside DM.

## Interface

Parameters:
- `PRESET_RST`, default 32'h0: reset value of the PRESET register.

Ports:
- `clk`  input  1  system clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `Sel`  input  1  device select from the bridge; gates all writes.
- `Addr`  input  32  byte address; only `Addr[3:2]` is decoded.
- `WE`  input  1  write strobe; a write occurs when `Sel & WE`.
- `BE`  input  4  byte enables for the write; `BE[i]` enables `WD[8i+7:8i]`.
- `WD`  input  32  write data.
- `RD`  output  32  read data, combinational from `Addr[3:2]`, independent of `Sel`.
- `IRQ`  output  1  interrupt request, equal to `CTRL.IM & pending`.

## Operation

- Registers:
  - 0x0 CTRL: [0] EN, [2:1] MODE, [3] IM. Bits [31:4] read 0 and are not writable.
  - 0x4 PRESET: 32-bit R/W.
  - 0x8 COUNT: read-only, writes ignored.
  - 0xC PRESCALE: see Configuration.
- Byte-enabled writes: only enabled bytes change. A write to CTRL with `BE[0]=0` leaves CTRL unchanged.
- MODE 0 is one-shot. MODE 1 is auto-reload. MODE 2/3 behave as MODE 0.
- FSM states:
  - IDLE: if EN=1, go to LOAD.
  - LOAD: COUNT <= PRESET, go to COUNT.
  - COUNT: if EN=0, go to IDLE. Else if COUNT==0, go to INT and set pending. Else COUNT <= COUNT-1 on each tick.
  - INT, MODE 0: EN <= 0, go to IDLE; pending stays set.
  - INT, MODE 1: pending <= 0, go to LOAD.
- A tick occurs every cycle in COUNT, unless gated by the prescaler.
- pending (MODE 0) is cleared by any write to CTRL or PRESET.
- Simultaneous events:
  - A CPU write to CTRL on the same edge as an FSM update of EN: the CPU write wins.
  - A write with EN=0 forces IDLE at that edge, from any state.
  - A write setting pending-clear on the same edge as INT entry: pending ends at 1 (set wins).
- A write to PRESET during COUNT does not disturb COUNT. The new value is used at the next LOAD.
- PRESET=0: LOAD -> COUNT -> INT with no decrement.
- `Addr` outside 0x0–0xC is impossible given the 2-bit decode; offsets alias every 16 bytes.

## Timing

- Reset (async): CTRL=0, PRESET=`PRESET_RST`, COUNT=0, PRESCALE=0, pending=0, state IDLE. IRQ=0 immediately. RD reflects the reset register values.
- Writes take effect on the rising edge where `Sel & WE`.
- `RD` is same-cycle combinational; the bridge registers it into W.
- Enable-to-IRQ latency, with PRESET=N, PRESCALE=0 and the EN write at edge 0:
  - Edge 1: LOAD.
  - Edge 2: COUNT=N.
  - Edges 3..N+2: decrement.
  - Edge N+3: INT, pending=1. IRQ rises after edge N+3.
- MODE 0: IRQ is held until cleared by a CPU write.
- MODE 1: IRQ is a one-cycle pulse. The period is N+3 cycles (INT -> LOAD -> COUNT...).
- Reset asserted mid-count aborts immediately to the reset state. No IRQ is generated.

## Configuration

- Macro: `TIMER_PRESCALE_EN`.
- Defined:
  - 0xC is an 8-bit PRESCALE register (R/W, bits [31:8] read 0).
  - An internal 8-bit prescale counter reloads to PRESCALE on LOAD and whenever it reaches 0.
  - A tick occurs only when the prescale counter is 0.
  - PRESCALE=0 gives a tick every cycle.
- Undefined: 0xC reads 0, writes are ignored, and a tick occurs every cycle in COUNT.

## Test plan

- Reset mid-operation: assert reset while COUNT=5 -> RD@0x8=0, RD@0x0=0 and IRQ=0 in the same cycle, with state IDLE.
- One-shot: PRESET=3, then write CTRL=0x9 (EN, MODE 0, IM) -> IRQ=1 six edges after the write. CTRL reads 0x8 afterward and IRQ stays 1. A write of PRESET=3 drops IRQ at the next edge.
- Auto-reload: PRESET=2, CTRL=0xB -> IRQ pulses for exactly one cycle every 5 cycles for at least 4 periods, with COUNT reading the sequence 2,1,0.
- Disable and mask: mid-count write CTRL=0x8 -> next cycle is IDLE, COUNT frozen at its current value and no IRQ. With CTRL=0x1 (IM=0), the count expires, pending is set internally and IRQ stays 0.
- Byte enables: write PRESET=0xAABBCCDD with BE=4'b0101 over a previous value of 0 -> RD@0x4=0x00BB00DD. A write to COUNT leaves it unchanged.
- Prescaler (with `TIMER_PRESCALE_EN`): PRESCALE=1, PRESET=2, MODE 0 -> IRQ latency grows from 5 to 7 edges. Without the macro, RD@0xC=0 after writing 0xFF.
